game_sequencer: RTL

Top-level game controller for the snake design. It owns the play/pause/game-over state machine and schedules `snake_step` at a rate that rises with fruit count. It issues fruit-placement requests and gates painter frame starts on `painter_busy`. It sits between the input/tick logic and the snake engine, fruit placer and painter, and replaces ad-hoc tick/step glue in the top level.

---
 rtl/game_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Snake game controller. Owns the IDLE/PLAY/PAUSE/OVER state
//                machine, paces snake_step by speed level, issues fruit
//                placement requests and gates painter frame starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int CLK_FREQ         = 50_000_000,
    parameter int BASE_RATE        = 4,
    parameter int RATE_INC         = 2,
    parameter int FRUITS_PER_LEVEL = 5,
    parameter int FRAME_RATE       = 30
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       ate_fruit,
    input  logic       game_over,
    input  logic       fruit_busy,
    input  logic       painter_busy,
    output logic       snake_step,
    output logic       fruit_req,
    output logic       frame_start,
    output logic       engine_clear,
    output logic [1:0] state,
    output logic [1:0] level,
    output logic [7:0] fruit_count
);

    // Step periods per level and the frame period, all in clock cycles.
    localparam logic [31:0] c_PERIOD_L0    = 32'(CLK_FREQ / (BASE_RATE + RATE_INC * 0));
    localparam logic [31:0] c_PERIOD_L1    = 32'(CLK_FREQ / (BASE_RATE + RATE_INC * 1));
    localparam logic [31:0] c_PERIOD_L2    = 32'(CLK_FREQ / (BASE_RATE + RATE_INC * 2));
    localparam logic [31:0] c_PERIOD_L3    = 32'(CLK_FREQ / (BASE_RATE + RATE_INC * 3));
    localparam logic [31:0] c_FRAME_PERIOD = 32'(CLK_FREQ / FRAME_RATE);
    localparam logic [31:0] c_FRUITS_LVL   = 32'(FRUITS_PER_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      r_state,        w_state;
    logic [31:0] r_step_cnt,     w_step_cnt;
    logic [31:0] r_in_level,     w_in_level;
    logic [31:0] r_frame_cnt,    w_frame_cnt;
    logic [1:0]  r_level,        w_level;
    logic [7:0]  r_fruit_count,  w_fruit_count;
    logic        r_pending,      w_pending;
    logic        r_booted;
    logic        r_snake_step,   w_snake_step;
    logic        r_fruit_req,    w_fruit_req;
    logic        r_frame_start,  w_frame_start;
    logic        r_engine_clear, w_engine_clear;
    logic [31:0] w_period_m1;
    logic        w_frame_wrap;
    logic        w_frame_fire;

    // State and output registers; reset also cancels any pending frame.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_step_cnt     <= '0;
            r_in_level     <= '0;
            r_frame_cnt    <= '0;
            r_level        <= '0;
            r_fruit_count  <= '0;
            r_pending      <= 1'b0;
            r_booted       <= 1'b0;
            r_snake_step   <= 1'b0;
            r_fruit_req    <= 1'b0;
            r_frame_start  <= 1'b0;
            r_engine_clear <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_step_cnt     <= w_step_cnt;
            r_in_level     <= w_in_level;
            r_frame_cnt    <= w_frame_cnt;
            r_level        <= w_level;
            r_fruit_count  <= w_fruit_count;
            r_pending      <= w_pending;
            r_booted       <= 1'b1;
            r_snake_step   <= w_snake_step;
            r_fruit_req    <= w_fruit_req;
            r_frame_start  <= w_frame_start;
            r_engine_clear <= w_engine_clear;
        end
    end

    // Next-state logic: game FSM, step pacing, fruit scoring and frame timer.
    always_comb begin
        w_state        = r_state;
        w_step_cnt     = r_step_cnt;
        w_in_level     = r_in_level;
        w_level        = r_level;
        w_fruit_count  = r_fruit_count;
        w_snake_step   = 1'b0;
        w_fruit_req    = 1'b0;
        w_engine_clear = 1'b0;

        case (r_level)
            2'd0:    w_period_m1 = c_PERIOD_L0 - 32'd1;
            2'd1:    w_period_m1 = c_PERIOD_L1 - 32'd1;
            2'd2:    w_period_m1 = c_PERIOD_L2 - 32'd1;
            default: w_period_m1 = c_PERIOD_L3 - 32'd1;
        endcase

        case (r_state)
            S_IDLE: begin
                w_step_cnt = '0;
                if (start_btn) begin
                    w_state     = S_PLAY;
                    w_fruit_req = 1'b1;
                end
            end
            S_PLAY: begin
                if (ate_fruit) begin
                    w_fruit_req = 1'b1;
                    if (r_fruit_count != 8'hFF) begin
                        w_fruit_count = r_fruit_count + 8'd1;
                    end
                    if (r_in_level + 32'd1 >= c_FRUITS_LVL) begin
                        w_in_level = '0;
                        if (r_level != 2'd3) begin
                            w_level = r_level + 2'd1;
                        end
                    end else begin
                        w_in_level = r_in_level + 32'd1;
                    end
                end
                // Game over beats pause, and both suppress a due step.
                if (game_over) begin
                    w_state = S_OVER;
                end else if (pause_btn) begin
                    w_state = S_PAUSE;
                end else if (r_step_cnt >= w_period_m1) begin
                    // A busy fruit placer holds the step at its terminal count.
                    if (!fruit_busy) begin
                        w_step_cnt   = '0;
                        w_snake_step = 1'b1;
                    end
                end else begin
                    w_step_cnt = r_step_cnt + 32'd1;
                end
            end
            S_PAUSE: begin
                if (game_over) begin
                    w_state = S_OVER;
                end else if (pause_btn) begin
                    w_state = S_PLAY;
                end
            end
            default: begin
                if (start_btn) begin
                    w_state        = S_IDLE;
                    w_engine_clear = 1'b1;
                    w_fruit_count  = '0;
                    w_level        = '0;
                    w_in_level     = '0;
                    w_step_cnt     = '0;
                end
            end
        endcase

        // Free-running frame timer with a single-entry pending latch.
        w_frame_wrap  = (r_frame_cnt >= c_FRAME_PERIOD - 32'd1);
        w_frame_cnt   = w_frame_wrap ? '0 : r_frame_cnt + 32'd1;
        w_frame_fire  = r_pending && !painter_busy;
        w_pending     = (r_pending && !w_frame_fire) || w_frame_wrap;
        w_frame_start = w_frame_fire || !r_booted;
    end

    assign snake_step   = r_snake_step;
    assign fruit_req    = r_fruit_req;
    assign frame_start  = r_frame_start;
    assign engine_clear = r_engine_clear;
    assign state        = r_state;
    assign level        = r_level;
    assign fruit_count  = r_fruit_count;

endmodule
`default_nettype wire
